page_table_walker: RTL and testbench

- Services TLB misses. Accepts a missing virtual address, walks a two-level page table in memory and produces the TLB refill triple `mmu_update_valid`/`mmu_vaddr`/`mmu_paddr`.
- Sits between the TLB miss path and the memory port; it is the producer side of the TLB update interface.
- Walk format: L1 index = vaddr[31:22], L0 index = vaddr[21:12], 4 KiB pages, 4 MiB superpages.

---
 rtl/page_table_walker_pkg.sv | 44 ++++
 rtl/page_table_walker_if.sv | 38 +++
 rtl/page_table_walker_pte_check.sv | 49 ++++
 rtl/page_table_walker.sv | 219 +++++++++++++++++++++
 tb/tb_page_table_walker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/page_table_walker_pkg.sv
// Shared types for the two-level page table walker: FSM states, PTE layout,
// fault codes, PTE classification results and PTE address helpers.
package ptw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L0_REQ  = 3'd3,
    ST_L0_WAIT = 3'd4,
    ST_UPDATE  = 3'd5,
    ST_FAULT   = 3'd6
  } ptw_state_e;

  typedef enum logic [1:0] {
    FC_INVALID_L1 = 2'd0,
    FC_BAD_L0     = 2'd1,
    FC_MISALIGNED = 2'd2,
    FC_TIMEOUT    = 2'd3
  } ptw_fault_e;

  typedef enum logic [1:0] {
    ACT_DESCEND = 2'd0,
    ACT_LEAF    = 2'd1,
    ACT_FAULT   = 2'd2
  } ptw_action_e;

  // PTE bit positions
  localparam int PPN_HI    = 31;
  localparam int PPN_LO    = 12;
  localparam int LEAF_BIT  = 1;
  localparam int VALID_BIT = 0;

  // Word address of the L1 PTE: root table page plus the top VPN field.
  function automatic logic [31:0] l1_addr(input logic [19:0] root_ppn, input logic [9:0] vpn1);
    return {root_ppn, vpn1, 2'b00};
  endfunction

  // Word address of the L0 PTE: second-level table page plus the low VPN field.
  function automatic logic [31:0] l0_addr(input logic [19:0] table_ppn, input logic [9:0] vpn0);
    return {table_ppn, vpn0, 2'b00};
  endfunction

endpackage

// File: rtl/page_table_walker_if.sv
// Bundle of the walker's miss, memory, TLB-refill and fault signals.
// master = the walker, slave = its environment (TLB miss path + memory + TLB).
interface page_table_walker_if;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_vaddr;
  logic [19:0] ptbr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_tag;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_tag;
  logic        mmu_update_valid;
  logic [31:0] mmu_vaddr;
  logic [31:0] mmu_paddr;
  logic        fault_valid;
  logic [31:0] fault_vaddr;
  logic [1:0]  fault_code;
  logic        busy;

  modport master (
    input  miss_valid, miss_vaddr, ptbr, mem_req_ready,
           mem_resp_valid, mem_resp_data, mem_resp_tag,
    output miss_ready, mem_req_valid, mem_req_addr, mem_req_tag,
           mmu_update_valid, mmu_vaddr, mmu_paddr,
           fault_valid, fault_vaddr, fault_code, busy
  );

  modport slave (
    output miss_valid, miss_vaddr, ptbr, mem_req_ready,
           mem_resp_valid, mem_resp_data, mem_resp_tag,
    input  miss_ready, mem_req_valid, mem_req_addr, mem_req_tag,
           mmu_update_valid, mmu_vaddr, mmu_paddr,
           fault_valid, fault_vaddr, fault_code, busy
  );
endinterface

// File: rtl/page_table_walker_pte_check.sv
// Combinational PTE classifier: decides whether a fetched PTE descends,
// terminates the walk as a leaf, or faults (and with which code).
module ptw_pte_check
  import ptw_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level_l1,
  output ptw_action_e action,
  output ptw_fault_e  code
);

  logic pte_valid_s;
  logic pte_leaf_s;
  logic misaligned_s;
  logic pte_unused_s;

  assign pte_valid_s  = pte[VALID_BIT];
  assign pte_leaf_s   = pte[LEAF_BIT];
  // A superpage must have its low PPN field clear; those bits come from the vaddr.
  assign misaligned_s = (pte[21:12] != 10'd0);
  assign pte_unused_s = ^{pte[PPN_HI:22], pte[11:2]};

  // Classify the PTE according to the level it was fetched from.
  always_comb begin
    action = ACT_FAULT;
    code   = FC_INVALID_L1;
    if (level_l1) begin
      if (!pte_valid_s) begin
        action = ACT_FAULT;
        code   = FC_INVALID_L1;
      end else if (pte_leaf_s && misaligned_s) begin
        action = ACT_FAULT;
        code   = FC_MISALIGNED;
      end else if (pte_leaf_s) begin
        action = ACT_LEAF;
      end else begin
        action = ACT_DESCEND;
      end
    end else begin
      if (pte_valid_s && pte_leaf_s) begin
        action = ACT_LEAF;
      end else begin
        action = ACT_FAULT;
        code   = FC_BAD_L0;
      end
    end
  end

endmodule

// File: rtl/page_table_walker.sv
// Two-level page table walker servicing TLB misses.
// Optional build macro PTW_WALK_CACHE_EN adds a single-entry cache of the last
// non-leaf L1 PTE so a repeat miss in the same 4 MiB region skips the L1 read.
module page_table_walker
  import ptw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic                 clk,
  input logic                 reset,
  page_table_walker_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ptw_state_e       state_r, state_next_s;
  logic [31:0]      vaddr_r, vaddr_next_s;
  logic [19:0]      ptbr_r, ptbr_next_s;
  logic [19:0]      l1_ppn_r, l1_ppn_next_s;
  logic             tag_r, tag_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [31:0]      mmu_vaddr_r, mmu_vaddr_next_s;
  logic [31:0]      mmu_paddr_r, mmu_paddr_next_s;
  logic [31:0]      fault_vaddr_r, fault_vaddr_next_s;
  ptw_fault_e       fault_code_r, fault_code_next_s;
  logic             resp_hit_s;
  logic             timeout_s;
  logic             wait_l1_s;
  ptw_action_e      chk_action_s;
  ptw_fault_e       chk_code_s;
`ifdef PTW_WALK_CACHE_EN
  logic             cache_valid_r, cache_valid_next_s;
  logic [19:0]      cache_ptbr_r, cache_ptbr_next_s;
  logic [9:0]       cache_vpn1_r, cache_vpn1_next_s;
  logic [19:0]      cache_ppn_r, cache_ppn_next_s;
  logic             cache_hit_s;

  assign cache_hit_s = cache_valid_r && (bus.ptbr == cache_ptbr_r) &&
                       (bus.miss_vaddr[31:22] == cache_vpn1_r);
`endif

  // The tag register has already toggled past the outstanding request, so a
  // matching response carries the opposite value; anything else is stale.
  assign resp_hit_s = bus.mem_resp_valid && (bus.mem_resp_tag != tag_r);
  assign timeout_s  = (cnt_r == CNT_LAST);
  assign wait_l1_s  = (state_r == ST_L1_WAIT);

  ptw_pte_check u_pte_check (
    .pte      (bus.mem_resp_data),
    .level_l1 (wait_l1_s),
    .action   (chk_action_s),
    .code     (chk_code_s)
  );

  // Next-state and next-register values for the walk FSM.
  always_comb begin
    state_next_s       = state_r;
    vaddr_next_s       = vaddr_r;
    ptbr_next_s        = ptbr_r;
    l1_ppn_next_s      = l1_ppn_r;
    tag_next_s         = tag_r;
    cnt_next_s         = cnt_r;
    mmu_vaddr_next_s   = mmu_vaddr_r;
    mmu_paddr_next_s   = mmu_paddr_r;
    fault_vaddr_next_s = fault_vaddr_r;
    fault_code_next_s  = fault_code_r;
`ifdef PTW_WALK_CACHE_EN
    cache_valid_next_s = cache_valid_r;
    cache_ptbr_next_s  = cache_ptbr_r;
    cache_vpn1_next_s  = cache_vpn1_r;
    cache_ppn_next_s   = cache_ppn_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.miss_valid) begin
          vaddr_next_s = bus.miss_vaddr;
          ptbr_next_s  = bus.ptbr;
`ifdef PTW_WALK_CACHE_EN
          if (cache_hit_s) begin
            l1_ppn_next_s = cache_ppn_r;
            state_next_s  = ST_L0_REQ;
          end else begin
            state_next_s  = ST_L1_REQ;
          end
          // A new root table makes the cached L1 entry meaningless.
          if (bus.ptbr != cache_ptbr_r) begin
            cache_valid_next_s = 1'b0;
          end else begin
            cache_valid_next_s = cache_valid_r;
          end
`else
          state_next_s = ST_L1_REQ;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_L1_REQ, ST_L0_REQ: begin
        if (bus.mem_req_ready) begin
          state_next_s = (state_r == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
          tag_next_s   = ~tag_r;
          cnt_next_s   = CNT_W'(0);
        end else begin
          state_next_s = state_r;
        end
      end
      ST_L1_WAIT, ST_L0_WAIT: begin
        // A matching response takes priority over a same-cycle timeout.
        if (resp_hit_s) begin
          case (chk_action_s)
            ACT_LEAF: begin
              mmu_vaddr_next_s = {vaddr_r[31:12], 12'h000};
              if (wait_l1_s) begin
                mmu_paddr_next_s = {bus.mem_resp_data[31:22], vaddr_r[21:12], 12'h000};
              end else begin
                mmu_paddr_next_s = {bus.mem_resp_data[PPN_HI:PPN_LO], 12'h000};
              end
              state_next_s = ST_UPDATE;
            end
            ACT_DESCEND: begin
              l1_ppn_next_s = bus.mem_resp_data[PPN_HI:PPN_LO];
`ifdef PTW_WALK_CACHE_EN
              cache_valid_next_s = 1'b1;
              cache_ptbr_next_s  = ptbr_r;
              cache_vpn1_next_s  = vaddr_r[31:22];
              cache_ppn_next_s   = bus.mem_resp_data[PPN_HI:PPN_LO];
`endif
              state_next_s = ST_L0_REQ;
            end
            ACT_FAULT: begin
              fault_vaddr_next_s = vaddr_r;
              fault_code_next_s  = chk_code_s;
              state_next_s       = ST_FAULT;
            end
            default: begin
              state_next_s = ST_IDLE;
            end
          endcase
        end else if (timeout_s) begin
          fault_vaddr_next_s = vaddr_r;
          fault_code_next_s  = FC_TIMEOUT;
          state_next_s       = ST_FAULT;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        state_next_s = ST_IDLE;
      end
      ST_FAULT: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any walk in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      vaddr_r       <= 32'h0000_0000;
      ptbr_r        <= 20'h0_0000;
      l1_ppn_r      <= 20'h0_0000;
      tag_r         <= 1'b0;
      cnt_r         <= CNT_W'(0);
      mmu_vaddr_r   <= 32'h0000_0000;
      mmu_paddr_r   <= 32'h0000_0000;
      fault_vaddr_r <= 32'h0000_0000;
      fault_code_r  <= FC_INVALID_L1;
`ifdef PTW_WALK_CACHE_EN
      cache_valid_r <= 1'b0;
      cache_ptbr_r  <= 20'h0_0000;
      cache_vpn1_r  <= 10'h000;
      cache_ppn_r   <= 20'h0_0000;
`endif
    end else begin
      state_r       <= state_next_s;
      vaddr_r       <= vaddr_next_s;
      ptbr_r        <= ptbr_next_s;
      l1_ppn_r      <= l1_ppn_next_s;
      tag_r         <= tag_next_s;
      cnt_r         <= cnt_next_s;
      mmu_vaddr_r   <= mmu_vaddr_next_s;
      mmu_paddr_r   <= mmu_paddr_next_s;
      fault_vaddr_r <= fault_vaddr_next_s;
      fault_code_r  <= fault_code_next_s;
`ifdef PTW_WALK_CACHE_EN
      cache_valid_r <= cache_valid_next_s;
      cache_ptbr_r  <= cache_ptbr_next_s;
      cache_vpn1_r  <= cache_vpn1_next_s;
      cache_ppn_r   <= cache_ppn_next_s;
`endif
    end
  end

  // Request address is built from registered fields only, so it stays stable under back-pressure.
  always_comb begin
    case (state_r)
      ST_L1_REQ: bus.mem_req_addr = l1_addr(ptbr_r, vaddr_r[31:22]);
      ST_L0_REQ: bus.mem_req_addr = l0_addr(l1_ppn_r, vaddr_r[21:12]);
      default:   bus.mem_req_addr = 32'h0000_0000;
    endcase
  end

  assign bus.miss_ready       = (state_r == ST_IDLE);
  assign bus.busy             = (state_r != ST_IDLE);
  assign bus.mem_req_valid    = (state_r == ST_L1_REQ) || (state_r == ST_L0_REQ);
  assign bus.mem_req_tag      = tag_r;
  assign bus.mmu_update_valid = (state_r == ST_UPDATE);
  assign bus.mmu_vaddr        = mmu_vaddr_r;
  assign bus.mmu_paddr        = mmu_paddr_r;
  assign bus.fault_valid      = (state_r == ST_FAULT);
  assign bus.fault_vaddr      = fault_vaddr_r;
  assign bus.fault_code       = fault_code_r;

endmodule

// File: tb/tb_page_table_walker.sv
// Directed testbench for page_table_walker with hand-computed PTE addresses
// and refill/fault values. Inputs change and outputs are sampled on negedge.
module tb_page_table_walker;

  logic clk = 1'b0;
  logic reset;
  int   checks_cnt = 0;
  int   errors_cnt = 0;
  logic exp_tag;
  logic req_tag;
  logic stale_tag;
  int   wait_n;

  page_table_walker_if bus ();

  page_table_walker #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a miss for one cycle; the walker must be idle.
  task automatic start_miss(input logic [31:0] va, input logic [19:0] pt);
    check_eq("miss_ready", {31'd0, bus.miss_ready}, 32'd1);
    bus.miss_valid = 1'b1;
    bus.miss_vaddr = va;
    bus.ptbr       = pt;
    tick();
    bus.miss_valid = 1'b0;
  endtask

  // Expect a request this cycle and complete its handshake (mem_req_ready high).
  task automatic expect_req(input string tag, input logic [31:0] addr);
    check_eq({tag, "_valid"}, {31'd0, bus.mem_req_valid}, 32'd1);
    check_eq({tag, "_addr"}, bus.mem_req_addr, addr);
    check_eq({tag, "_tag"}, {31'd0, bus.mem_req_tag}, {31'd0, exp_tag});
    req_tag = exp_tag;
    exp_tag = ~exp_tag;
    tick();
  endtask

  task automatic respond(input logic [31:0] data, input logic tg);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = data;
    bus.mem_resp_tag   = tg;
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic expect_update(input string tag, input logic [31:0] va, input logic [31:0] pa);
    check_eq({tag, "_upd"}, {31'd0, bus.mmu_update_valid}, 32'd1);
    check_eq({tag, "_vaddr"}, bus.mmu_vaddr, va);
    check_eq({tag, "_paddr"}, bus.mmu_paddr, pa);
    check_eq({tag, "_nofault"}, {31'd0, bus.fault_valid}, 32'd0);
    tick();
    check_eq({tag, "_upd_end"}, {31'd0, bus.mmu_update_valid}, 32'd0);
    check_eq({tag, "_paddr_hold"}, bus.mmu_paddr, pa);
    check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic expect_fault(input string tag, input logic [31:0] va, input logic [1:0] code);
    check_eq({tag, "_flt"}, {31'd0, bus.fault_valid}, 32'd1);
    check_eq({tag, "_code"}, {30'd0, bus.fault_code}, {30'd0, code});
    check_eq({tag, "_fvaddr"}, bus.fault_vaddr, va);
    check_eq({tag, "_noupd"}, {31'd0, bus.mmu_update_valid}, 32'd0);
    tick();
    check_eq({tag, "_flt_end"}, {31'd0, bus.fault_valid}, 32'd0);
    check_eq({tag, "_code_hold"}, {30'd0, bus.fault_code}, {30'd0, code});
    check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset              = 1'b0;
    bus.miss_valid     = 1'b0;
    bus.miss_vaddr     = 32'h0000_0000;
    bus.ptbr           = 20'h0_0000;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0000_0000;
    bus.mem_resp_tag   = 1'b0;
    exp_tag            = 1'b0;
    req_tag            = 1'b0;
    stale_tag          = 1'b0;
    wait_n             = 0;
    repeat (2) tick();

    // Reset state
    check_eq("rst_miss_ready", {31'd0, bus.miss_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq("rst_tag", {31'd0, bus.mem_req_tag}, 32'd0);
    check_eq("rst_upd", {31'd0, bus.mmu_update_valid}, 32'd0);
    check_eq("rst_flt", {31'd0, bus.fault_valid}, 32'd0);
    check_eq("rst_paddr", bus.mmu_paddr, 32'h0000_0000);
    check_eq("rst_fvaddr", bus.fault_vaddr, 32'h0000_0000);
    reset = 1'b1;
    tick();

    // Two-level walk, zero-wait memory: update lands five cycles after accept.
    start_miss(32'h1234_5678, 20'h00010);
    expect_req("w1_l1", 32'h0001_0120);
    respond(32'h0002_0001, req_tag);
    expect_req("w1_l0", 32'h0002_0D14);
    respond(32'hABCD_E003, req_tag);
    expect_update("w1", 32'h1234_5000, 32'hABCD_E000);

    // Same 4 MiB region and root: with the walk cache only the L0 read is issued.
    start_miss(32'h1234_7000, 20'h00010);
`ifndef PTW_WALK_CACHE_EN
    expect_req("w2_l1", 32'h0001_0120);
    respond(32'h0002_0001, req_tag);
`endif
    expect_req("w2_l0", 32'h0002_0D1C);
    respond(32'h5555_5003, req_tag);
    expect_update("w2", 32'h1234_7000, 32'h5555_5000);

    // New root: L1 read is issued again; aligned superpage refills at c3.
    start_miss(32'h1234_5678, 20'h00011);
    expect_req("sp_l1", 32'h0001_1120);
    respond(32'h0840_0003, req_tag);
    expect_update("sp", 32'h1234_5000, 32'h0874_5000);

    // Misaligned superpage
    start_miss(32'h1234_5678, 20'h00011);
    expect_req("mis_l1", 32'h0001_1120);
    respond(32'h0840_1003, req_tag);
    expect_fault("mis", 32'h1234_5678, 2'd2);

    // Invalid L1 entry
    start_miss(32'h1234_5678, 20'h00011);
    expect_req("inv_l1", 32'h0001_1120);
    respond(32'h0000_0000, req_tag);
    expect_fault("inv", 32'h1234_5678, 2'd0);

    // Non-leaf L0 entry
    start_miss(32'h1234_5678, 20'h00011);
    expect_req("bad_l1", 32'h0001_1120);
    respond(32'h0002_0001, req_tag);
    expect_req("bad_l0", 32'h0002_0D14);
    respond(32'h0002_0001, req_tag);
    expect_fault("bad", 32'h1234_5678, 2'd1);
    check_eq("paddr_hold_faults", bus.mmu_paddr, 32'h0874_5000);

    // Back-pressure: request fields stay put while mem_req_ready is low.
    bus.mem_req_ready = 1'b0;
    start_miss(32'h4000_0000, 20'h00011);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check_eq("bp_addr", bus.mem_req_addr, 32'h0001_1400);
      check_eq("bp_tag", {31'd0, bus.mem_req_tag}, {31'd0, exp_tag});
      tick();
    end
    bus.mem_req_ready = 1'b1;
    expect_req("bp_l1", 32'h0001_1400);
    stale_tag = req_tag;

    // No response: 16 wait cycles, then the timeout fault pulse.
    wait_n = 0;
    while ((bus.fault_valid !== 1'b1) && (wait_n < 40)) begin
      tick();
      wait_n++;
    end
    check_eq("to_cycles", wait_n, 32'd16);
    expect_fault("to", 32'h4000_0000, 2'd3);

    // A late response with the old tag is ignored; the walk still completes.
    start_miss(32'h4000_0000, 20'h00011);
    expect_req("late_l1", 32'h0001_1400);
    respond(32'h0000_0000, stale_tag);
    check_eq("late_busy", {31'd0, bus.busy}, 32'd1);
    check_eq("late_noflt", {31'd0, bus.fault_valid}, 32'd0);
    check_eq("late_noreq", {31'd0, bus.mem_req_valid}, 32'd0);
    respond(32'h0840_0003, req_tag);
    expect_update("late", 32'h4000_0000, 32'h0840_0000);

    // Reset while waiting for the L0 response aborts at once.
    start_miss(32'h1234_5678, 20'h00020);
    expect_req("rw_l1", 32'h0002_0120);
    respond(32'h0002_0001, req_tag);
    expect_req("rw_l0", 32'h0002_0D14);
    reset = 1'b0;
    #1;
    check_eq("rw_miss_ready", {31'd0, bus.miss_ready}, 32'd1);
    check_eq("rw_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rw_tag", {31'd0, bus.mem_req_tag}, 32'd0);
    check_eq("rw_upd", {31'd0, bus.mmu_update_valid}, 32'd0);
    check_eq("rw_flt", {31'd0, bus.fault_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hABCD_E003;
    bus.mem_resp_tag   = req_tag;
    tick();
    reset   = 1'b1;
    exp_tag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_resp_valid = 1'b0;
      check_eq("rw_after_upd", {31'd0, bus.mmu_update_valid}, 32'd0);
      check_eq("rw_after_flt", {31'd0, bus.fault_valid}, 32'd0);
      check_eq("rw_after_busy", {31'd0, bus.busy}, 32'd0);
    end

    // Walker is usable again after reset, starting from tag 0.
    start_miss(32'h1234_5678, 20'h00010);
    expect_req("post_l1", 32'h0001_0120);
    respond(32'h0840_0003, req_tag);
    expect_update("post", 32'h1234_5000, 32'h0874_5000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
